// File: rtl/led_fader_pkg.sv
// Shared LED definitions: state encodings, the dimmer level width and
// saturating level arithmetic used by the fader and the dimmer stage.
package led_fader_pkg;

  localparam int LEVEL_W           = 12;
  localparam int DEFAULT_MAX_LEVEL = 4094;

  typedef logic [LEVEL_W-1:0] level_t;
  typedef logic [LEVEL_W:0]   wide_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RISE    = 3'd1,
    ST_HOLD_HI = 3'd2,
    ST_FALL    = 3'd3,
    ST_HOLD_LO = 3'd4
  } led_state_t;

  // Add with one spare bit so the sum cannot wrap before clamping to top.
  function automatic level_t sat_add(input level_t lvl, input wide_t inc, input wide_t top);
    wide_t sum;
    sum = wide_t'(lvl) + inc;
    if (sum >= top) return level_t'(top);
    return level_t'(sum);
  endfunction

  // Subtract, clamping at zero instead of wrapping.
  function automatic level_t sat_sub(input level_t lvl, input wide_t dec);
    wide_t diff;
    if (wide_t'(lvl) < dec) return '0;
    diff = wide_t'(lvl) - dec;
    return level_t'(diff);
  endfunction

endpackage

// File: rtl/led_fader_tick_gen.sv
// Fade step prescaler: counts 0..DIV-1 while enabled, strobes on the last
// count and parks at zero while disabled.
module tick_gen #(
  parameter int DIV = 24414
) (
  input  logic CLK,
  input  logic RSTN,
  input  logic EN,
  output logic STB
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t LAST = cnt_t'(DIV - 1);

  cnt_t cnt;

  assign STB = EN && (cnt == LAST);

  // Free-running divider while enabled, held at zero otherwise.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      cnt <= '0;
    end else if (!EN) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/led_fader.sv
// LED fader: ramps the dimmer level up, holds, ramps down, holds, and
// repeats while the board switch is on.
module led_fader
  import led_fader_pkg::*;
#(
  parameter int STEP_DIV   = 24414,
  parameter int STEP       = 1,
  parameter int MAX_LEVEL  = DEFAULT_MAX_LEVEL,
  parameter int HOLD_STEPS = 512
) (
  input  logic               CLK,
  input  logic               RSTN,
  input  logic               SW,
  output logic [LEVEL_W-1:0] LEVEL,
  output logic               TICK,
  output logic [2:0]         STATE
);

  localparam int HW        = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;
  localparam int HOLD_LAST = (HOLD_STEPS > 0) ? HOLD_STEPS - 1 : 0;
  typedef logic [HW-1:0] hold_t;

  localparam wide_t  STEP_W   = wide_t'(STEP);
  localparam wide_t  MAX_W    = wide_t'(MAX_LEVEL);
  localparam level_t MAX_L    = level_t'(MAX_LEVEL);
  localparam hold_t  HOLD_END = hold_t'(HOLD_LAST);

  logic       sw_m, sw_s;
  logic       stb;
  led_state_t state, state_n;
  level_t     level, level_n, next_lvl;
  hold_t      hold, hold_n;
  logic       tick, tick_n;

  tick_gen #(.DIV(STEP_DIV)) u_tick_gen (
    .CLK  (CLK),
    .RSTN (RSTN),
    .EN   (state != ST_IDLE),
    .STB  (stb)
  );

  // Two-flop synchronizer for the asynchronous board switch.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      sw_m <= 1'b0;
      sw_s <= 1'b0;
    end else begin
      sw_m <= SW;
      sw_s <= sw_m;
    end
  end

  // Next-state, next-level and plateau counting for the fade cycle.
  always_comb begin
    state_n  = state;
    level_n  = level;
    hold_n   = hold;
    tick_n   = 1'b0;
    next_lvl = level;
    case (state)
      ST_IDLE: begin
        level_n = '0;
        hold_n  = '0;
        if (sw_s) state_n = ST_RISE;
      end
      ST_RISE: begin
        hold_n = '0;
        if (!sw_s) begin
          state_n = ST_FALL;
        end else if (stb) begin
          next_lvl = sat_add(level, STEP_W, MAX_W);
          level_n  = next_lvl;
          tick_n   = (next_lvl != level);
          if (next_lvl == MAX_L) state_n = ST_HOLD_HI;
        end
      end
      ST_HOLD_HI: begin
        if (!sw_s || HOLD_STEPS == 0) begin
          state_n = ST_FALL;
          hold_n  = '0;
        end else if (stb) begin
          if (hold == HOLD_END) begin
            state_n = ST_FALL;
            hold_n  = '0;
          end else begin
            hold_n = hold + 1'b1;
          end
        end
      end
      ST_FALL: begin
        hold_n = '0;
        if (stb) begin
          next_lvl = sat_sub(level, STEP_W);
          level_n  = next_lvl;
          tick_n   = (next_lvl != level);
          if (next_lvl == '0) state_n = sw_s ? ST_HOLD_LO : ST_IDLE;
        end
      end
      ST_HOLD_LO: begin
        if (HOLD_STEPS == 0) begin
          state_n = sw_s ? ST_RISE : ST_IDLE;
          hold_n  = '0;
        end else if (stb) begin
          if (hold == HOLD_END) begin
            state_n = sw_s ? ST_RISE : ST_IDLE;
            hold_n  = '0;
          end else begin
            hold_n = hold + 1'b1;
          end
        end
      end
      default: begin
        state_n = ST_IDLE;
        level_n = '0;
        hold_n  = '0;
      end
    endcase
  end

  // Registered FSM state and outputs.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state <= ST_IDLE;
      level <= '0;
      hold  <= '0;
      tick  <= 1'b0;
    end else begin
      state <= state_n;
      level <= level_n;
      hold  <= hold_n;
      tick  <= tick_n;
    end
  end

  assign LEVEL = level;
  assign TICK  = tick;
  assign STATE = state;

endmodule

// File: tb/tb_led_fader.sv
// Self-checking bench for led_fader: two instances (ramping and full-swing
// toggling) compared cycle by cycle against a behavioural model.
module tb_led_fader;

  logic        clk = 1'b0;
  logic        rstnA, swA, rstnB, swB;
  logic [11:0] levelA, levelB;
  logic        tickA, tickB;
  logic [2:0]  stateA, stateB;

  int compared   = 0;
  int mismatched = 0;
  bit checking   = 0;
  int tickCountA = 0;
  int tickCountB = 0;

  always #5 clk = ~clk;

  led_fader #(.STEP_DIV(4), .STEP(1000), .MAX_LEVEL(4094), .HOLD_STEPS(2)) dutA (
    .CLK(clk), .RSTN(rstnA), .SW(swA), .LEVEL(levelA), .TICK(tickA), .STATE(stateA)
  );

  led_fader #(.STEP_DIV(4), .STEP(4094), .MAX_LEVEL(4094), .HOLD_STEPS(0)) dutB (
    .CLK(clk), .RSTN(rstnB), .SW(swB), .LEVEL(levelB), .TICK(tickB), .STATE(stateB)
  );

  // Behavioural model: mode numbers are the documented STATE values
  // (0 idle, 1 rise, 2 hold high, 3 fall, 4 hold low).
  typedef struct {
    int level;
    int mode;
    int phase;
    int holdCnt;
    bit sw0;
    bit sw1;
    bit tick;
  } model_t;

  model_t mA, mB;

  function automatic model_t nextModel(input model_t m, input bit rstn, input bit sw,
                                       input int div, input int step, input int maxl, input int hold);
    model_t n;
    bit     swS;
    bit     isStep;
    int     lv;
    if (!rstn) begin
      n = '{0, 0, 0, 0, 0, 0, 0};
      return n;
    end
    n      = m;
    n.tick = 0;
    swS    = m.sw1;
    n.sw1  = m.sw0;
    n.sw0  = sw;
    isStep = (m.mode != 0) && (m.phase == div - 1);
    n.phase = (m.mode == 0) ? 0 : (m.phase + 1) % div;
    case (m.mode)
      0: begin
        n.level = 0;
        if (swS) n.mode = 1;
      end
      1: begin
        n.holdCnt = 0;
        if (!swS) n.mode = 3;
        else if (isStep) begin
          lv = (m.level + step > maxl) ? maxl : m.level + step;
          n.tick  = (lv != m.level);
          n.level = lv;
          if (lv == maxl) n.mode = 2;
        end
      end
      2: begin
        if (!swS || hold == 0) begin
          n.mode = 3; n.holdCnt = 0;
        end else if (isStep) begin
          n.holdCnt = m.holdCnt + 1;
          if (n.holdCnt == hold) begin n.mode = 3; n.holdCnt = 0; end
        end
      end
      3: begin
        n.holdCnt = 0;
        if (isStep) begin
          lv = (m.level - step < 0) ? 0 : m.level - step;
          n.tick  = (lv != m.level);
          n.level = lv;
          if (lv == 0) n.mode = swS ? 4 : 0;
        end
      end
      default: begin
        if (hold == 0) begin
          n.mode = swS ? 1 : 0; n.holdCnt = 0;
        end else if (isStep) begin
          n.holdCnt = m.holdCnt + 1;
          if (n.holdCnt == hold) begin n.mode = swS ? 1 : 0; n.holdCnt = 0; end
        end
      end
    endcase
    return n;
  endfunction

  // Advance both models on every rising edge with the inputs the DUTs see.
  always @(posedge clk) begin
    mA = nextModel(mA, rstnA, swA, 4, 1000, 4094, 2);
    mB = nextModel(mB, rstnB, swB, 4, 4094, 4094, 0);
  end

  task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    if (checking) begin
      compare("A.level", {20'b0, levelA}, mA.level);
      compare("A.tick",  {31'b0, tickA},  {31'b0, mA.tick});
      compare("A.state", {29'b0, stateA}, mA.mode);
      compare("B.level", {20'b0, levelB}, mB.level);
      compare("B.tick",  {31'b0, tickB},  {31'b0, mB.tick});
      compare("B.state", {29'b0, stateB}, mB.mode);
      compare("B.bound", {31'b0, (levelB <= 12'd4094)}, 1);
      if (tickA === 1'b1) tickCountA++;
      if (tickB === 1'b1) tickCountB++;
    end
  endtask

  task automatic applyStimulus(input bit rA, input bit sA, input bit rB, input bit sB, input int cycles);
    rstnA = rA; swA = sA; rstnB = rB; swB = sB;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      checkOutput();
    end
  endtask

  initial begin
    bit found;
    int len;
    mA = '{0, 0, 0, 0, 0, 0, 0};
    mB = '{0, 0, 0, 0, 0, 0, 0};

    // Reset both instances, then idle with the switch off.
    applyStimulus(0, 0, 0, 0, 3);
    checking = 1;
    applyStimulus(1, 0, 1, 0, 1);
    compare("reset.levelA", {20'b0, levelA}, 0);
    compare("reset.stateA", {29'b0, stateA}, 0);
    tickCountA = 0;
    tickCountB = 0;
    applyStimulus(1, 0, 1, 0, 50);
    compare("idle.ticksA", tickCountA, 0);
    compare("idle.ticksB", tickCountB, 0);

    // Switch on: RISE three cycles later, first step four cycles after that.
    applyStimulus(1, 1, 1, 1, 3);
    compare("rise.stateA", {29'b0, stateA}, 1);
    applyStimulus(1, 1, 1, 1, 4);
    compare("rise.firstA", {20'b0, levelA}, 1000);
    compare("rise.firstB", {20'b0, levelB}, 4094);
    applyStimulus(1, 1, 1, 1, 20);
    tickCountB = 0;
    applyStimulus(1, 1, 1, 1, 40);
    compare("toggle.ticksB", tickCountB, 10);

    // Drop the switch while rising at 2000, with a one-cycle pulse mid-fall.
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      applyStimulus(1, 1, 1, 1, 1);
      if (mA.level == 2000 && mA.mode == 1) found = 1;
    end
    compare("wait.level2000", {31'b0, found}, 1);
    applyStimulus(1, 0, 1, 1, 4);
    applyStimulus(1, 1, 1, 1, 1);
    applyStimulus(1, 0, 1, 1, 20);
    compare("drop.stateA", {29'b0, stateA}, 0);
    compare("drop.levelA", {20'b0, levelA}, 0);

    // Reset mid-ramp at 3000, then restart from zero.
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      applyStimulus(1, 1, 1, 1, 1);
      if (mA.level == 3000) found = 1;
    end
    compare("wait.level3000", {31'b0, found}, 1);
    applyStimulus(0, 1, 1, 1, 1);
    compare("midreset.levelA", {20'b0, levelA}, 0);
    compare("midreset.stateA", {29'b0, stateA}, 0);
    applyStimulus(1, 1, 1, 1, 10);
    compare("restart.stateA", {29'b0, stateA}, 1);
    compare("restart.levelA", {20'b0, levelA}, 1000);

    // Random switch activity with occasional resets.
    for (int seg = 0; seg < 40; seg++) begin
      len = $urandom_range(1, 30);
      if ($urandom_range(0, 15) == 0)
        applyStimulus(0, 1'($urandom_range(0, 1)), 1, 1'($urandom_range(0, 3) != 0), 1);
      else
        applyStimulus(1, 1'($urandom_range(0, 1)), 1, 1'($urandom_range(0, 3) != 0), len);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Safety net so the run always terminates.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
